// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the jump/branch target logic.
//   jmode_e      : request mode encoding (J, JAL, JR, BRANCH)
//   PC_INC_NEXT  : distance from a jump/branch to its delay-slot successor
//   PC_INC_LINK  : distance from a JAL to its return address
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        MODE_J      = 2'b00,
        MODE_JAL    = 2'b01,
        MODE_JR     = 2'b10,
        MODE_BRANCH = 2'b11
    } jmode_e;

    localparam int unsigned PC_INC_NEXT = 4;
    localparam int unsigned PC_INC_LINK = 8;

endpackage

// File: rtl/jump_target_calc.sv
// -----------------------------------------------------------------------------
// jump_target_calc
// Purely combinational target / link computation for one request.
//   mode_i      : request mode (mips_pkg::jmode_e encoding)
//   pc_i        : address of the jump/branch instruction
//   idx_i       : jump index field; idx_i[15:0] doubles as the branch offset
//   rs_i        : register operand used by JR
//   target_o    : computed target address
//   link_o      : return address (JAL only, otherwise 0)
//   link_we_o   : link register write enable (JAL only)
//   misalign_o  : target is not word aligned
// -----------------------------------------------------------------------------
module jump_target_calc
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 26
) (
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [ADDR_W-1:0] rs_i,
    output logic [ADDR_W-1:0] target_o,
    output logic [ADDR_W-1:0] link_o,
    output logic              link_we_o,
    output logic              misalign_o
);

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] region;
    logic [ADDR_W-1:0] jump_off;
    logic [ADDR_W-1:0] branch_off;

    assign pc_next = pc_i + ADDR_W'(PC_INC_NEXT);

    // Keep only the bits of pc+4 above the index field. When IDX_W+2 equals
    // ADDR_W the shift clears everything, which is the intended empty region.
    assign region   = (pc_next >> (IDX_W + 2)) << (IDX_W + 2);
    assign jump_off = ADDR_W'({idx_i, 2'b00});

    // Sign-extend the 16-bit offset to full width before scaling to bytes.
    assign branch_off = ADDR_W'(signed'(idx_i[15:0])) << 2;

    always_comb begin
        target_o  = '0;
        link_o    = '0;
        link_we_o = 1'b0;
        unique case (jmode_e'(mode_i))
            MODE_J: begin
                target_o = region | jump_off;
            end
            MODE_JAL: begin
                target_o  = region | jump_off;
                link_o    = pc_i + ADDR_W'(PC_INC_LINK);
                link_we_o = 1'b1;
            end
            MODE_JR: begin
                target_o = rs_i;
            end
            MODE_BRANCH: begin
                target_o = pc_next + branch_off;
            end
            default: begin
                target_o = '0;
            end
        endcase
    end

    assign misalign_o = |target_o[1:0];

endmodule

// File: rtl/jump_target_unit.sv
// -----------------------------------------------------------------------------
// jump_target_unit
// Computes jump/branch targets and buffers them in a 2-entry result FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake
//   mode_i, pc_i, idx_i, rs_i : request fields
//   flush_i             : drop every buffered result
//   out_valid / out_ready : result handshake
//   target_o, link_o, link_we_o, misalign_o : result fields (0 when empty)
//   redirect_cnt_o      : saturating count of consumed results
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on valid, and a presented result holds its
// fields until it is taken.
// -----------------------------------------------------------------------------
module jump_target_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 26,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] target_o,
    output logic [ADDR_W-1:0] link_o,
    output logic              link_we_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  redirect_cnt_o
);

    logic [ADDR_W-1:0] calc_target;
    logic [ADDR_W-1:0] calc_link;
    logic              calc_link_we;
    logic              calc_misalign;

    jump_target_calc #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_calc (
        .mode_i     (mode_i),
        .pc_i       (pc_i),
        .idx_i      (idx_i),
        .rs_i       (rs_i),
        .target_o   (calc_target),
        .link_o     (calc_link),
        .link_we_o  (calc_link_we),
        .misalign_o (calc_misalign)
    );

    logic [ADDR_W-1:0] target_mem_q [2];
    logic [ADDR_W-1:0] link_mem_q   [2];
    logic [1:0]        link_we_mem_q;
    logic [1:0]        misalign_mem_q;

    logic [1:0]       count_q, count_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic push;
    logic pop;

    // Readiness depends only on occupancy, so a full FIFO refuses a push even
    // if it is being drained in the same cycle.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        wptr_d  = wptr_q ^ push;
        rptr_d  = rptr_q ^ pop;
        // A flush empties the FIFO but a result popped alongside it was
        // already delivered, so the counter still sees that pop.
        if (flush_i) begin
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end
        cnt_d = cnt_q;
        if (pop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q         <= 2'd0;
            wptr_q          <= 1'b0;
            rptr_q          <= 1'b0;
            cnt_q           <= '0;
            target_mem_q[0] <= '0;
            target_mem_q[1] <= '0;
            link_mem_q[0]   <= '0;
            link_mem_q[1]   <= '0;
            link_we_mem_q   <= '0;
            misalign_mem_q  <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            if (push) begin
                target_mem_q[wptr_q]   <= calc_target;
                link_mem_q[wptr_q]     <= calc_link;
                link_we_mem_q[wptr_q]  <= calc_link_we;
                misalign_mem_q[wptr_q] <= calc_misalign;
            end
        end
    end

    // Fields are forced to zero while nothing is presented.
    assign target_o       = out_valid ? target_mem_q[rptr_q]   : '0;
    assign link_o         = out_valid ? link_mem_q[rptr_q]     : '0;
    assign link_we_o      = out_valid ? link_we_mem_q[rptr_q]  : 1'b0;
    assign misalign_o     = out_valid ? misalign_mem_q[rptr_q] : 1'b0;
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_jump_target_unit.sv
module tb_jump_target_unit;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 26;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mode_i;
    logic [ADDR_W-1:0] pc_i;
    logic [IDX_W-1:0]  idx_i;
    logic [ADDR_W-1:0] rs_i;
    logic              flush_i;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] target_o;
    logic [ADDR_W-1:0] link_o;
    logic              link_we_o;
    logic              misalign_o;
    logic [CNT_W-1:0]  redirect_cnt_o;

    int n_checks;
    int n_fail;

    // {target, link, link_we, misalign}
    logic [65:0] exp_q[$];

    jump_target_unit #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mode_i         (mode_i),
        .pc_i           (pc_i),
        .idx_i          (idx_i),
        .rs_i           (rs_i),
        .flush_i        (flush_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .target_o       (target_o),
        .link_o         (link_o),
        .link_we_o      (link_we_o),
        .misalign_o     (misalign_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] m, input logic [31:0] pc,
                           input logic [25:0] idx, input logic [31:0] rs);
        mode_i = m;
        pc_i   = pc;
        idx_i  = idx;
        rs_i   = rs;
    endtask

    // Drive one request, wait (bounded) for acceptance, record its expectation.
    task automatic send(input logic [1:0] m, input logic [31:0] pc,
                        input logic [25:0] idx, input logic [31:0] rs,
                        input logic [31:0] e_tgt, input logic [31:0] e_link,
                        input logic e_we, input logic e_mis);
        int n;
        set_req(m, pc, idx, rs);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({e_tgt, e_link, e_we, e_mis});
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: target 0x%0h with no expectation", target_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_target",   64'(target_o),   64'(e[65:34]));
                chk("sb_link",     64'(link_o),     64'(e[33:2]));
                chk("sb_link_we",  64'(link_we_o),  64'(e[1]));
                chk("sb_misalign", 64'(misalign_o), 64'(e[0]));
            end
        end else if (!out_valid) begin
            chk("idle_zero", {target_o, link_o[29:0], link_we_o, misalign_o}, 64'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_i   = 1'b0;
        set_req(2'b00, 32'h0, 26'h0, 32'h0);

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_cnt",       64'(redirect_cnt_o), 64'd0);
        chk("rst_target",    64'(target_o), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // J: result visible the cycle after acceptance
        out_ready = 1'b1;
        send(2'b00, 32'h00400000, 26'd9563, 32'h0, 32'h0000956C, 32'h0, 1'b0, 1'b0);
        chk("j_latency_valid", 64'(out_valid), 64'd1);
        // JAL
        send(2'b01, 32'h10000020, 26'h0000010, 32'h0, 32'h10000040, 32'h10000028, 1'b1, 1'b0);
        // BRANCH backwards by one word
        send(2'b11, 32'h00400010, 26'h000FFFF, 32'h0, 32'h00400010, 32'h0, 1'b0, 1'b0);
        // JR misaligned still delivered
        send(2'b10, 32'h0, 26'h0, 32'h00400003, 32'h00400003, 32'h0, 1'b0, 1'b1);
        // BRANCH forward
        send(2'b11, 32'h00001000, 26'h0000010, 32'h0, 32'h00001044, 32'h0, 1'b0, 1'b0);
        // BRANCH wrapping past the top of the address space
        send(2'b11, 32'hFFFFFFF0, 26'h0000008, 32'h0, 32'h00000014, 32'h0, 1'b0, 1'b0);
        // J with all index bits set and a non-zero region (pc+4 crosses region)
        send(2'b00, 32'hAFFFFFFC, 26'h3FFFFFF, 32'h0, 32'hBFFFFFFC, 32'h0, 1'b0, 1'b0);
        drain();
        chk("cnt_after_7", 64'(redirect_cnt_o), 64'd7);
        // counter saturates at 2^CNT_W-1
        send(2'b10, 32'h0, 26'h0, 32'h00000100, 32'h00000100, 32'h0, 1'b0, 1'b0);
        drain();
        chk("cnt_saturated", 64'(redirect_cnt_o), 64'd7);

        // Back-pressure: two accepted, third refused
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
        send(2'b00, 32'h00400000, 26'h0000001, 32'h0, 32'h00000004, 32'h0, 1'b0, 1'b0);
        send(2'b01, 32'h00000100, 26'h0000040, 32'h0, 32'h00000100, 32'h00000108, 1'b1, 1'b0);
        set_req(2'b10, 32'h0, 26'h0, 32'h00001234);
        in_valid = 1'b1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("full_in_ready_hold", 64'(in_ready), 64'd0);
        chk("stall_target_stable", 64'(target_o), 64'h00000004);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("cnt_after_pair", 64'(redirect_cnt_o), 64'd2);

        // Flush with same-cycle push and pop at occupancy 1
        out_ready = 1'b0;
        send(2'b10, 32'h0, 26'h0, 32'h00000200, 32'h00000200, 32'h0, 1'b0, 1'b0);
        set_req(2'b10, 32'h0, 26'h0, 32'h00000300);
        in_valid  = 1'b1;
        flush_i   = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        flush_i  = 1'b0;
        chk("flush_pop_out_valid", 64'(out_valid), 64'd0);
        chk("flush_pop_cnt", 64'(redirect_cnt_o), 64'd3);

        // Flush with same-cycle push, nothing consumed
        out_ready = 1'b0;
        send(2'b10, 32'h0, 26'h0, 32'h00000400, 32'h00000400, 32'h0, 1'b0, 1'b0);
        set_req(2'b10, 32'h0, 26'h0, 32'h00000500);
        in_valid = 1'b1;
        flush_i  = 1'b1;
        step();
        exp_q.delete();
        in_valid = 1'b0;
        flush_i  = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("flush_push_dropped", 64'(out_valid), 64'd0);
        chk("flush_cnt", 64'(redirect_cnt_o), 64'd3);

        // Reset while full
        send(2'b10, 32'h0, 26'h0, 32'h00000600, 32'h00000600, 32'h0, 1'b0, 1'b0);
        send(2'b10, 32'h0, 26'h0, 32'h00000700, 32'h00000700, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_cnt", 64'(redirect_cnt_o), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_target", 64'(target_o), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        send(2'b11, 32'h00002000, 26'h0000001, 32'h0, 32'h00002008, 32'h0, 1'b0, 1'b0);
        drain();
        chk("post_rst_cnt", 64'(redirect_cnt_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
